// File: rtl/alu_seq.sv
// alu_seq: parametrised handshaked ALU with iterative multiply/divide.
// Single-cycle ops register their result at accept; MUL and DIV (b != 0)
// iterate for WIDTH cycles. Results are held in DONE until out_ready.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL = 4'd2,  OP_DIV  = 4'd3,
    OP_SHR  = 4'd4,  OP_SHL  = 4'd5,  OP_ROL = 4'd6,  OP_ROR  = 4'd7,
    OP_GT   = 4'd8,  OP_LT   = 4'd9,  OP_AND = 4'd10, OP_NAND = 4'd11,
    OP_OR   = 4'd12, OP_NOR  = 4'd13, OP_XOR = 4'd14, OP_XNOR = 4'd15
  } op_t;

  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] m_q;      // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] hi_q;     // partial product high half / partial remainder
  logic [WIDTH-1:0] lo_q;     // multiplier being shifted out / quotient being shifted in
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   add_sum, sub_diff;
  logic [WIDTH-1:0] s_res, s_hi;
  logic             s_carry, s_dbz, shift_oob, start_busy;

  logic [WIDTH:0]   mul_sum, div_rem, div_try;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;

  assign add_sum    = {1'b0, a} + {1'b0, b};
  assign sub_diff   = {1'b0, a} - {1'b0, b};
  assign shift_oob  = (b >= WIDTH'(WIDTH));
  assign start_busy = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle result and flags, computed directly from the live inputs at accept
  always_comb begin
    s_res   = '0;
    s_hi    = '0;
    s_carry = 1'b0;
    s_dbz   = 1'b0;
    case (op)
      OP_ADD:  begin s_res = add_sum[WIDTH-1:0];  s_carry = add_sum[WIDTH];  end
      OP_SUB:  begin s_res = sub_diff[WIDTH-1:0]; s_carry = sub_diff[WIDTH]; end
      OP_DIV:  begin
        if (b == '0) begin
          s_res = '1;
          s_hi  = a;
          s_dbz = 1'b1;
        end
      end
      OP_SHR:  s_res = shift_oob ? '0 : (a >> b[SHW-1:0]);
      OP_SHL:  s_res = shift_oob ? '0 : (a << b[SHW-1:0]);
      OP_ROL:  s_res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  s_res = {b[0], b[WIDTH-1:1]};
      OP_GT:   s_res = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_LT:   s_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_AND:  s_res = a & b;
      OP_NAND: s_res = ~(a & b);
      OP_OR:   s_res = a | b;
      OP_NOR:  s_res = ~(a | b);
      OP_XOR:  s_res = a ^ b;
      OP_XNOR: s_res = ~(a ^ b);
      default: s_res = '0;
    endcase
  end

  assign mul_sum = {1'b0, hi_q} + {1'b0, m_q};
  assign div_rem = {hi_q, lo_q[WIDTH-1]};
  assign div_try = div_rem - {1'b0, m_q};

  // One iteration step: shift-add multiply or restoring divide
  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (op_q == OP_MUL) begin
      if (lo_q[0]) {hi_nxt, lo_nxt} = {mul_sum, lo_q[WIDTH-1:1]};
      else         {hi_nxt, lo_nxt} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end else if (div_try[WIDTH]) begin
      hi_nxt = div_rem[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
    end else begin
      hi_nxt = div_try[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = start_busy ? BUSY : DONE;
      BUSY:    if (cnt_q == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration registers and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      m_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      result      <= '0;
      result_hi   <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            cnt_q <= '0;
            hi_q  <= '0;
            if (op == OP_MUL) begin
              m_q  <= a;
              lo_q <= b;
            end else begin
              m_q  <= b;
              lo_q <= a;
            end
            if (!start_busy) begin
              result      <= s_res;
              result_hi   <= s_hi;
              carry       <= s_carry;
              zero        <= (s_res == '0);
              div_by_zero <= s_dbz;
            end
          end
        end
        BUSY: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_q + CW'(1);
          // The final iteration's combinational result is registered directly,
          // so MUL and DIV both leave product-low/quotient in lo, high/remainder in hi.
          if (cnt_q == CW'(WIDTH - 1)) begin
            result      <= lo_nxt;
            result_hi   <= hi_nxt;
            carry       <= 1'b0;
            zero        <= (lo_nxt == '0);
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 8-bit combinational ALU.
- Same 16-op set, generalised to WIDTH bits, with proper 4-bit binary opcodes.
- Adds a full-width multiply and quotient/remainder divide, both iterative (multi-cycle).
- Adds zero, carry and divide-by-zero flags, plus valid/ready on input and output so it can sit between pipeline stages of the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), derived; number of low bits of b used as shift amount for range check.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  4  opcode.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  primary result.
- result_hi  output  WIDTH  product upper half (MUL), remainder (DIV), else 0.
- carry  output  1  carry out (ADD) / borrow (SUB), else 0.
- zero  output  1  result == 0.
- div_by_zero  output  1  DIV issued with b == 0.

Behaviour:
- Reset (async assert, sync release): state IDLE; in_ready=1; out_valid=0; result, result_hi, carry, zero, div_by_zero all 0; internal accumulators cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. in_valid=1 latches a, b, op.
  - MUL, or DIV with b!=0 -> BUSY.
  - All other ops -> compute in the same cycle, register outputs -> DONE.
- BUSY: in_ready=0. Runs WIDTH iterations, one per clock.
  - MUL: shift-add.
  - DIV: restoring division.
  - After the final iteration, register outputs -> DONE.
- DONE: out_valid=1, in_ready=0. Outputs are held stable until out_ready=1; that cycle -> IDLE.
  - No accept in the DONE->IDLE cycle.
  - Maximum throughput: one op per 2 cycles (single-cycle ops).
- Latency, accept edge to out_valid:
  - 1 cycle for single-cycle ops and for divide-by-zero.
  - WIDTH+1 cycles for MUL and for DIV with b!=0.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Opcode map:
  - 0 ADD: {carry,result}=a+b.
  - 1 SUB: result=a-b mod 2^WIDTH; carry=1 iff a<b.
  - 2 MUL: {result_hi,result}=a*b, full 2*WIDTH product.
  - 3 DIV: result=a/b, result_hi=a%b, unsigned.
  - 4 SHR: result=a>>b (logical).
  - 5 SHL: result=a<<b.
  - 6 ROL: rotate a left by 1.
  - 7 ROR: rotate b right by 1.
  - 8 GT: result=(a>b)?1:0, unsigned.
  - 9 LT: result=(a<b)?1:0, unsigned.
  - 10 AND, 11 NAND, 12 OR, 13 NOR, 14 XOR, 15 XNOR.
- Shifts: if b >= WIDTH (any bit above SHW set, or value >= WIDTH), result=0.
- Divide by zero: result=all ones, result_hi=a, div_by_zero=1, 1-cycle latency, no BUSY.
- div_by_zero=0 for all other ops. carry=0 for all ops except ADD/SUB. result_hi=0 except MUL/DIV.
- zero reflects result only, never result_hi.
- Operands are latched at accept; later changes on a/b/op do not affect an in-flight op.
- rst_n asserted mid-BUSY or mid-DONE: immediate return to reset state. Pending result is discarded; out_valid drops asynchronously.
- Back-pressure: out_ready may stay low indefinitely. Outputs and flags must not change while out_valid=1.

Test Plan:
- Reset with in_valid=1 held: in_ready=1, out_valid=0, all outputs 0. After release, first op accepted on the next edge.
- ADD a=200,b=100 -> 1 cycle later result=0x2C, carry=1, zero=0. SUB a=5,b=7 -> result=0xFE, carry=1. SUB a=7,b=7 -> result=0, zero=1, carry=0.
- MUL a=200,b=3 -> out_valid exactly 9 cycles after accept; result=0x58, result_hi=0x02. MUL a=255,b=255 -> result=0x01, result_hi=0xFE.
- DIV a=200,b=7 -> 9 cycles later result=28, result_hi=4, div_by_zero=0. DIV a=9,b=0 -> 1 cycle later result=0xFF, result_hi=9, div_by_zero=1.
- SHL a=0x81,b=1 -> 0x02. SHR a=0x80,b=8 -> 0x00. ROL a=0x81 -> 0x03. ROR b=0x01 -> 0x80. GT a=3,b=2 -> 1. NOR a=0xF0,b=0x0F -> 0x00 with zero=1.
- Back-pressure and mid-op reset:
  - Hold out_ready=0 for 5 cycles after a MUL: result stable, in_ready=0, and new in_valid is ignored.
  - Assert rst_n low in BUSY cycle 4: out_valid=0 immediately; post-reset DIV 100/10 returns 10 r 0.
